// File: rtl/cw_if.sv
// Control-word handshake plus decoded datapath fields and commit strobes.
// master drives the control word and memory ack; slave is the executor.
interface cw_if;
  logic [46:0] cw_in;
  logic        cw_valid;
  logic        cw_ready;
  logic        mem_ack;

  logic [2:0]  da;
  logic [2:0]  aa;
  logic [2:0]  ba;
  logic [4:0]  fs;
  logic [1:0]  ps;
  logic [15:0] k;
  logic        mb;
  logic        md;
  logic        cs;
  logic [3:0]  misc;

  logic        mem_rd;
  logic        mem_wr;
  logic        reg_we;
  logic        pc_en;
  logic        ir_load;
  logic        status_ld;
  logic [1:0]  ns;
  logic        ns_valid;
  logic        err;
  logic        err_sticky;

  modport master (
    output cw_in, cw_valid, mem_ack,
    input  cw_ready, da, aa, ba, fs, ps, k, mb, md, cs, misc,
    input  mem_rd, mem_wr, reg_we, pc_en, ir_load, status_ld,
    input  ns, ns_valid, err, err_sticky
  );

  modport slave (
    input  cw_in, cw_valid, mem_ack,
    output cw_ready, da, aa, ba, fs, ps, k, mb, md, cs, misc,
    output mem_rd, mem_wr, reg_we, pc_en, ir_load, status_ld,
    output ns, ns_valid, err, err_sticky
  );
endinterface

// File: rtl/cw_executor.sv
// Registers an accepted control word, drives its fields, and commits side effects once:
// 1 cycle after accept for ALU words, on mem_ack (or abort after TIMEOUT WAIT cycles) for memory words.
module cw_executor #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  cw_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  ns;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [4:0]  fs;
    logic        mb;
    logic        md;
    logic        pce;
    logic        sl;
    logic        mw;
    logic [1:0]  ps;
    logic        il;
    logic        rw;
    logic [3:0]  misc;
    logic        mr;
    logic [15:0] k;
    logic        cs;
  } cw_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  cw_t        cw_q, cw_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_sticky_q, err_sticky_d;

  logic is_mem;
  logic is_illegal;
  logic ready_raw;
  logic cw_ready;
  logic handshake;
  logic commit;
  logic mem_rd;
  logic mem_wr;
  logic err;

  assign is_mem     = cw_q.mr ^ cw_q.mw;
  assign is_illegal = cw_q.mr & cw_q.mw;

  // Ready is masked by rst so no word is consumed on the reset edge.
  assign ready_raw  = (state_q == S_IDLE) ||
                      ((state_q == S_EXEC) && !is_mem && !is_illegal);
  assign cw_ready   = ready_raw & ~rst;
  assign handshake  = bus.cw_valid & cw_ready;

  always_comb begin
    state_d      = state_q;
    cw_d         = cw_q;
    cnt_d        = cnt_q;
    err_sticky_d = err_sticky_q;
    commit       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    err          = 1'b0;

    if (handshake) begin
      cw_d = cw_t'(bus.cw_in);
    end

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_illegal) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (is_mem) begin
          mem_rd  = cw_q.mr;
          mem_wr  = cw_q.mw;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          commit  = 1'b1;
          state_d = handshake ? S_EXEC : S_IDLE;
        end
      end

      S_WAIT: begin
        mem_rd = cw_q.mr;
        mem_wr = cw_q.mw;
        cnt_d  = cnt_q + 8'd1;
        // An ack landing on the timeout cycle still completes the transfer.
        if (bus.mem_ack) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cw_q         <= '0;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cw_q         <= cw_d;
      cnt_q        <= cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.cw_ready   = cw_ready;

  assign bus.da         = cw_q.da;
  assign bus.aa         = cw_q.aa;
  assign bus.ba         = cw_q.ba;
  assign bus.fs         = cw_q.fs;
  assign bus.ps         = cw_q.ps;
  assign bus.k          = cw_q.k;
  assign bus.mb         = cw_q.mb;
  assign bus.md         = cw_q.md;
  assign bus.cs         = cw_q.cs;
  assign bus.misc       = cw_q.misc;
  assign bus.ns         = cw_q.ns;

  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.reg_we     = commit & cw_q.rw;
  assign bus.pc_en      = commit & cw_q.pce;
  assign bus.ir_load    = commit & cw_q.il;
  assign bus.status_ld  = commit & cw_q.sl;
  assign bus.ns_valid   = commit;
  assign bus.err        = err;
  assign bus.err_sticky = err_sticky_q;

endmodule
